// File: rtl/fir_outfmt_decim.sv
// fir_outfmt_decim: decimates the FIR result stream, rounds half-to-even,
// saturates to OW bits and buffers results in a 2-entry FWFT output FIFO.
module fir_outfmt_decim #(
    parameter int IW    = 31,
    parameter int OW    = 16,
    parameter int SHIFT = 8,
    parameter int DECIM = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_sat,
    output logic          o_drop
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RW = IW + 1 - SHIFT;  // width of the rounded value
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [IW:0] HALF_M1 = (IW+1)'((2 ** (SHIFT - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_HI = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_LO = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef struct packed {
        logic          sat;
        logic [OW-1:0] data;
    } ent_t;

    logic [CW-1:0]        dcnt_q;
    logic                 keep;
    logic [1:0]           vld_pipe_q;   // [0]=stage 1, [1]=stage 2
    logic signed [IW:0]   sum;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r_q;
    ent_t                 s2_q;
    ent_t                 s2_d;
    ent_t                 head_q, head_d;
    ent_t                 tail_q, tail_d;
    logic [1:0]           fcnt_q, fcnt_d;
    logic                 pop;
    logic                 push;

    assign keep = i_ce && (dcnt_q == '0);

    // Decimation phase: advances on every input strobe, wraps at DECIM-1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            dcnt_q <= '0;
        else if (i_ce)
            dcnt_q <= (dcnt_q == CNT_LAST) ? '0 : dcnt_q + 1'b1;
    end

    // Convergent rounding: bias by half-minus-one plus the LSB that survives,
    // one guard bit keeps the add from overflowing.
    assign sum = $signed({i_data[IW-1], i_data}) + $signed(HALF_M1)
               + $signed({{IW{1'b0}}, i_data[SHIFT]});
    assign rnd = RW'(sum >>> SHIFT);

    // Saturate the rounded value to the output word.
    always_comb begin
        s2_d.sat  = 1'b0;
        s2_d.data = OW'(r_q);
        if (r_q > SAT_HI) begin
            s2_d.sat  = 1'b1;
            s2_d.data = OW'(SAT_HI);
        end else if (r_q < SAT_LO) begin
            s2_d.sat  = 1'b1;
            s2_d.data = OW'(SAT_LO);
        end
    end

    // Two pipeline stages; valid bits shift along, data only loads when valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_pipe_q <= '0;
            r_q        <= '0;
            s2_q       <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], keep};
            if (keep)
                r_q <= rnd;
            if (vld_pipe_q[0])
                s2_q <= s2_d;
        end
    end

    assign pop    = (fcnt_q != 2'd0) && i_ready;
    assign push   = vld_pipe_q[1] && ((fcnt_q != 2'd2) || pop);
    assign o_drop = vld_pipe_q[1] && (fcnt_q == 2'd2) && !pop;

    // FIFO next state: head is the output register, tail is the second slot.
    // The head is only overwritten by a new entry, so outputs hold when empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b11: begin
                if (fcnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = s2_q;
                end else begin
                    head_d = s2_q;
                end
            end
            2'b10: begin
                if (fcnt_q == 2'd0)
                    head_d = s2_q;
                else
                    tail_d = s2_q;
                fcnt_d = fcnt_q + 2'd1;
            end
            2'b01: begin
                if (fcnt_q == 2'd2)
                    head_d = tail_q;
                fcnt_d = fcnt_q - 2'd1;
            end
            default: ;
        endcase
    end

    // FIFO state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head_q <= '0;
            tail_q <= '0;
            fcnt_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign o_valid = (fcnt_q != 2'd0);
    assign o_data  = head_q.data;
    assign o_sat   = head_q.sat;
endmodule

// File: tb/tb_fir_outfmt_decim.sv
// Directed bench: one DECIM=1 instance for rounding/saturation/FIFO tests,
// one DECIM=4 instance for decimation and phase restart after reset.
module tb_fir_outfmt_decim;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ce1 = 1'b0, rdy1 = 1'b1;
    logic [30:0] d1 = '0;
    logic        v1, s1, dr1;
    logic [15:0] od1;
    logic        ce4 = 1'b0, rdy4 = 1'b1;
    logic [30:0] d4 = '0;
    logic        v4, s4, dr4;
    logic [15:0] od4;

    int checks = 0;
    int failures = 0;
    int drops1 = 0;

    fir_outfmt_decim #(.IW(31), .OW(16), .SHIFT(8), .DECIM(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce1), .i_data(d1), .o_valid(v1),
        .i_ready(rdy1), .o_data(od1), .o_sat(s1), .o_drop(dr1));

    fir_outfmt_decim #(.IW(31), .OW(16), .SHIFT(8), .DECIM(4)) u4 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce4), .i_data(d4), .o_valid(v4),
        .i_ready(rdy4), .o_data(od4), .o_sat(s4), .o_drop(dr4));

    // count drop pulses mid-cycle
    always @(negedge clk) if (dr1 === 1'b1) drops1++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one kept sample on u1 with i_ready=1; check 3-clock latency and result
    task automatic rnd(input string tag, input int din, input int eo, input int es);
        ce1 = 1'b1; d1 = 31'(din);
        tick;
        ce1 = 1'b0;
        chk({tag, "_v0"}, {31'd0, v1}, 0);
        tick;
        chk({tag, "_v1"}, {31'd0, v1}, 0);
        tick;
        chk({tag, "_v"}, {31'd0, v1}, 1);
        chk({tag, "_d"}, $signed(od1), eo);
        chk({tag, "_s"}, {31'd0, s1}, es);
    endtask

    initial begin
        // reset state
        tick; tick;
        chk("rst_v1", {31'd0, v1}, 0);
        chk("rst_d1", $signed(od1), 0);
        chk("rst_s1", {31'd0, s1}, 0);
        chk("rst_dr1", {31'd0, dr1}, 0);
        chk("rst_v4", {31'd0, v4}, 0);
        rst = 1'b0;
        tick;

        // decimation by 4 on u4: only samples 0 and 4 survive
        for (int k = 0; k < 8; k++) begin
            ce4 = 1'b1; d4 = 31'(k * 256);
            tick;
            ce4 = 1'b0;
            chk($sformatf("dec%0d_n0", k), {31'd0, v4}, 0);
            tick;
            chk($sformatf("dec%0d_n1", k), {31'd0, v4}, 0);
            tick;
            if (k % 4 == 0) begin
                chk($sformatf("dec%0d_v", k), {31'd0, v4}, 1);
                chk($sformatf("dec%0d_d", k), $signed(od4), k);
            end else begin
                chk($sformatf("dec%0d_v", k), {31'd0, v4}, 0);
            end
            tick;
        end

        // rounding (half to even) and saturation on u1
        rnd("r1p5",  384, 2, 0);
        rnd("r2p5",  640, 2, 0);
        rnd("r3p5",  896, 4, 0);
        rnd("rm1p5", -384, -2, 0);
        rnd("r383",  383, 1, 0);
        rnd("sat_hi", (1 << 30) - 1, 32767, 1);
        rnd("sat_lo", -(1 << 30), -32768, 1);
        rnd("max_ok", 32767 * 256, 32767, 0);
        rnd("max_half", 32767 * 256 + 128, 32767, 1);
        rnd("min_ok", -32768 * 256, -32768, 0);
        tick;
        chk("rnd_empty", {31'd0, v1}, 0);
        chk("rnd_hold", $signed(od1), -32768);

        // backpressure: third write is dropped
        rdy1 = 1'b0; drops1 = 0;
        ce1 = 1'b1; d1 = 31'(256); tick;
        d1 = 31'(512); tick;
        d1 = 31'(768); tick;
        ce1 = 1'b0;
        repeat (4) tick;
        chk("bp_drops", drops1, 1);
        chk("bp_v", {31'd0, v1}, 1);
        chk("bp_d0", $signed(od1), 1);
        rdy1 = 1'b1;
        tick;
        chk("bp_v1", {31'd0, v1}, 1);
        chk("bp_d1", $signed(od1), 2);
        tick;
        chk("bp_empty", {31'd0, v1}, 0);
        chk("bp_hold", $signed(od1), 2);

        // full FIFO with a pop in the same cycle as the third write
        rdy1 = 1'b0; drops1 = 0;
        ce1 = 1'b1; d1 = 31'(256); tick;
        d1 = 31'(512); tick;
        d1 = 31'(768); tick;
        ce1 = 1'b0;
        tick;
        chk("fp_v", {31'd0, v1}, 1);
        chk("fp_d0", $signed(od1), 1);
        rdy1 = 1'b1;
        tick;
        chk("fp_d1", $signed(od1), 2);
        tick;
        chk("fp_v2", {31'd0, v1}, 1);
        chk("fp_d2", $signed(od1), 3);
        tick;
        chk("fp_empty", {31'd0, v1}, 0);
        chk("fp_drops", drops1, 0);

        // reset mid-stream: FIFO full plus one result in flight
        rdy1 = 1'b0; drops1 = 0;
        ce1 = 1'b1; d1 = 31'(256);
        ce4 = 1'b1; d4 = 31'(9 * 256);
        tick;
        ce4 = 1'b0;
        d1 = 31'(512); tick;
        d1 = 31'(768); tick;
        ce1 = 1'b0;
        tick;
        chk("mr_full", {31'd0, v1}, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_v1", {31'd0, v1}, 0);
        chk("mr_d1", $signed(od1), 0);
        chk("mr_dr1", {31'd0, dr1}, 0);
        chk("mr_v4", {31'd0, v4}, 0);
        tick; tick;
        rst = 1'b0;
        tick;
        chk("mr_stale1", {31'd0, v1}, 0);
        tick;
        chk("mr_stale1b", {31'd0, v1}, 0);
        chk("mr_stale4", {31'd0, v4}, 0);
        ce1 = 1'b1; d1 = 31'(7 * 256);
        ce4 = 1'b1; d4 = 31'(5 * 256);
        tick;
        ce1 = 1'b0; ce4 = 1'b0;
        tick; tick;
        chk("mr_v1_new", {31'd0, v1}, 1);
        chk("mr_d1_new", $signed(od1), 7);
        chk("mr_v4_new", {31'd0, v4}, 1);
        chk("mr_d4_new", $signed(od4), 5);
        chk("mr_drops", drops1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_outfmt_decim.md
Name: fir_outfmt_decim

Overview:
- Output formatter that sits directly downstream of the slow FIR filter and consumes its o_ce/o_result stream.
- Decimates the result stream by a fixed ratio, applies convergent rounding (round-half-to-even), then saturates to a narrower word.
- Presents results on a valid/ready interface through a 2-entry output FIFO, so a stalled consumer never stalls the filter.

Parameters:
IW, 31, input result width (matches filter OW = 2*12+7); signed
OW, 16, output sample width; signed
SHIFT, 8, LSBs dropped by rounding; legal range 1 <= SHIFT and IW-SHIFT >= OW
DECIM, 4, decimation ratio; 1 = pass every sample; legal range 1..256

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_ce  in  1  input sample strobe (filter o_ce)
i_data  in  IW  signed filter result (filter o_result), valid when i_ce
o_valid  out  1  o_data/o_sat hold a result
i_ready  in  1  consumer accepts; transfer occurs when o_valid && i_ready
o_data  out  OW  signed rounded/saturated result
o_sat  out  1  result was clamped; qualified by o_valid
o_drop  out  1  one-cycle pulse: a result was discarded because the FIFO was full

Behaviour:
- Reset (async assert, release synchronous to i_clk) clears the following:
  - decimation counter to 0
  - pipeline valid bits
  - FIFO, to empty
- Output values while in reset: o_valid=0, o_data=0, o_sat=0, o_drop=0.
- Decimation:
  - The counter advances only on i_ce and wraps from DECIM-1 to 0.
  - A sample is kept when i_ce=1 and counter==0. Samples 0, DECIM, 2*DECIM, ... after reset are kept.
  - When i_ce=0, the counter holds.
- Stage 1, registered at the edge where a kept sample arrives (edge N):
  - Compute r = (sext(i_data, IW+1) + (2^(SHIFT-1) - 1) + i_data[SHIFT]) >>> SHIFT.
  - The arithmetic shift gives round-half-to-even. The IW+1-bit width rules out internal overflow.
- Stage 2, at edge N+1:
  - If r > 2^(OW-1)-1, o_data = 2^(OW-1)-1 and sat=1.
  - If r < -2^(OW-1), o_data = -2^(OW-1) and sat=1.
  - Otherwise o_data = r[OW-1:0] and sat=0.
- FIFO write, at edge N+2:
  - {sat, data} is written to the FIFO.
  - With an empty FIFO, o_valid is high in the cycle after edge N+2. Total latency is 3 clocks from acceptance to o_valid.
- FIFO:
  - 2 entries; first-word-fall-through; o_data/o_sat show the head entry.
  - Head is stable while o_valid && !i_ready.
  - Pop on o_valid && i_ready.
- Write when full:
  - If a pop occurs in the same cycle, the write is accepted and the occupancy stays 2.
  - If no pop occurs, the new result is discarded and o_drop pulses for exactly that one cycle. FIFO contents are unchanged.
- Write to an empty FIFO with i_ready=1: no bypass. The entry appears next cycle.
- The pipeline never stalls. i_ce may be asserted every cycle, including back-to-back kept samples when DECIM=1.
- Reset mid-operation: in-flight pipeline results and FIFO contents are discarded, and the decimation phase restarts at 0.
- o_sat and o_data are don't-care when o_valid=0. The RTL holds them at their last value, no toggling.

Test Plan:
- Rounding, IW=31/SHIFT=8/OW=16/DECIM=1:
  - i_data=384 (1.5) -> 2
  - 640 (2.5) -> 2
  - 896 (3.5) -> 4
  - -384 -> -2
  - 383 -> 1
  - all with o_sat=0
- Saturation:
  - i_data=2^30-1 -> o_data=32767, o_sat=1
  - i_data=-2^30 -> o_data=-32768, o_sat=1
  - i_data=32767*256 -> 32767, o_sat=0
- Decimation and latency:
  - Setup: DECIM=4, i_ready=1, i_ce pulsed on 8 samples with values k*256 for k=0..7, gaps of 3 idle cycles.
  - Outputs are exactly 0 then 4.
  - o_valid rises 3 clocks after each kept i_ce.
- Backpressure and drop:
  - Setup: DECIM=1, i_ready=0, three kept samples 1*256, 2*256, 3*256.
  - FIFO holds 1, 2; o_drop pulses once at the third write.
  - Raising i_ready yields 1 then 2, then o_valid=0.
- Full + simultaneous pop:
  - Setup: FIFO full (1, 2); i_ready=1 in the same cycle a third result (3) is written.
  - No o_drop; outputs 1, 2, 3 in order.
- Reset mid-stream:
  - Setup: assert i_reset asynchronously (between edges) with FIFO holding 2 entries and 1 sample in the pipeline.
  - o_valid=0 immediately; no stale output after release.
  - Decimation restarts: first i_ce after release is kept.
